// File: rtl/fp_mac_accum_pkg.sv
// Shared types and helpers for the multiply-accumulate block: accumulator state encoding
// and IEEE754 exponent helpers parameterised by exponent width.
// Latency: none (types and constant functions only). Backpressure: not applicable.
package fp_mac_accum_pkg;

  // ACC: products flow into the accumulator. HOLD: a finished group sum waits on out_ready.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Exponent bias for an nx-bit exponent field.
  function automatic int exp_offset(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

  // All-ones exponent: marks inf/nan and is the overflow threshold.
  function automatic int exp_max(input int nx);
    return (1 << nx) - 1;
  endfunction

endpackage

// File: rtl/fpu.sv
// Combinational IEEE754(NX,NM) multiplier and adder shared by the MAC datapath.
// Latency: 0 cycles (pure combinational). Backpressure: none, the user registers results.
// Semantics: truncating, denormals flushed to zero, inf/nan operands passed through unchanged.
// Modport mul_mp drives mul_a/mul_b and reads mul_y; add_mp drives add_a/add_b and reads add_y.
interface fpu #(
  parameter int NX = 11,
  parameter int NM = 23
) ();
  import fp_mac_accum_pkg::*;

  localparam int N    = NX + NM + 1;
  localparam int BIAS = exp_offset(NX);
  localparam int EMAX = exp_max(NX);

  typedef struct packed {
    logic          sign;
    logic [NX-1:0] exp;
    logic [NM-1:0] man;
  } fp_t;

  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [N-1:0] mul_y;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N-1:0] add_y;

  function automatic logic [N-1:0] f_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    fp_t             x, y, r;
    logic [2*NM+1:0] ma, mb, prod;
    int              e;
    x      = a;
    y      = b;
    r      = '0;
    r.sign = x.sign ^ y.sign;
    ma     = '0;
    mb     = '0;
    prod   = '0;
    e      = 0;
    if (&x.exp) begin
      r = x;
    end else if (&y.exp) begin
      r = y;
    end else if (x.exp != '0 && y.exp != '0) begin
      ma   = {{(NM+1){1'b0}}, 1'b1, x.man};
      mb   = {{(NM+1){1'b0}}, 1'b1, y.man};
      prod = ma * mb;
      e    = int'(x.exp) + int'(y.exp) - BIAS;
      // Product of two [1,2) significands lies in [1,4); renormalise the [2,4) case.
      if (prod[2*NM+1]) begin
        e     = e + 1;
        r.man = prod[2*NM:NM+1];
      end else begin
        r.man = prod[2*NM-1:NM];
      end
      if (e >= EMAX) begin
        r.exp = '1;
        r.man = '0;
      end else if (e <= 0) begin
        r.exp = '0;
        r.man = '0;
      end else begin
        r.exp = e[NX-1:0];
      end
    end
    return r;
  endfunction

  // Both operands are treated as normal numbers (hidden bit set); zero handling is the caller's job.
  function automatic logic [N-1:0] f_add(input logic [N-1:0] a, input logic [N-1:0] b);
    fp_t         x, y, big, sml, r;
    logic [NM+1:0] mb, ms, sum;
    int          d, e;
    x   = a;
    y   = b;
    r   = '0;
    big = x;
    sml = y;
    mb  = '0;
    ms  = '0;
    sum = '0;
    d   = 0;
    e   = 0;
    if (&x.exp) begin
      r = x;
    end else if (&y.exp) begin
      r = y;
    end else begin
      if ({x.exp, x.man} < {y.exp, y.man}) begin
        big = y;
        sml = x;
      end
      d  = int'(big.exp) - int'(sml.exp);
      mb = {1'b0, 1'b1, big.man};
      ms = {1'b0, 1'b1, sml.man} >> d;
      e  = int'(big.exp);
      if (big.sign == sml.sign) begin
        sum = mb + ms;
        if (sum[NM+1]) begin
          sum = sum >> 1;
          e   = e + 1;
        end
      end else begin
        sum = mb - ms;
        for (int i = 0; i <= NM; i++) begin
          if (sum != '0 && !sum[NM]) begin
            sum = sum << 1;
            e   = e - 1;
          end
        end
      end
      if (sum == '0 || e <= 0) begin
        r = '0;
      end else if (e >= EMAX) begin
        r.sign = big.sign;
        r.exp  = '1;
        r.man  = '0;
      end else begin
        r.sign = big.sign;
        r.exp  = e[NX-1:0];
        r.man  = sum[NM-1:0];
      end
    end
    return r;
  endfunction

  always_comb mul_y = f_mul(mul_a, mul_b);
  always_comb add_y = f_add(add_a, add_b);

  modport mul_mp (output mul_a, output mul_b, input mul_y);
  modport add_mp (output add_a, output add_b, input add_y);

endinterface

// File: rtl/fp_mul_stage.sv
// Product register P: multiplies each accepted operand pair and holds one product (depth-1 skid).
// Latency: 1 cycle from input transfer to p_valid.
// Backpressure: in_ready drops only while P is full and the consumer (p_ready) is not draining it.
// Ports: clk/rst; in_valid/in_ready/in_a/in_b/in_last upstream; p_ready in, p_valid/p_q/p_last out;
//        fpu_if multiplier modport.
module fp_mul_stage
  import fp_mac_accum_pkg::*;
#(
  parameter  int NX = 11,
  parameter  int NM = 23,
  localparam int N  = NX + NM + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_last,
  input  logic         p_ready,
  output logic         p_valid,
  output logic [N-1:0] p_q,
  output logic         p_last,
  fpu.mul_mp           fpu_if
);

  // A full P is only a problem when the consumer is not taking it this cycle.
  assign in_ready     = p_ready || !p_valid;
  assign fpu_if.mul_a = in_a;
  assign fpu_if.mul_b = in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_q     <= '0;
      p_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      p_valid <= 1'b1;
      p_q     <= fpu_if.mul_y;
      p_last  <= in_last;
    end else if (p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mac_accum.sv
// Streaming MAC: multiplies operand pairs and sums each in_last-terminated group, one sum per group.
// Latency: last pair accepted in cycle t -> out_valid in cycle t+2 when out_ready is not stalling.
// Backpressure: while a sum waits on out_ready, one product of the next group is buffered, then in_ready drops.
// Ports: clk/rst; in_valid/in_ready/in_a/in_b/in_last pair input;
//        out_valid/out_ready/out_sum/out_count/out_abn group result.
module fp_mac_accum
  import fp_mac_accum_pkg::*;
#(
  parameter  int NX    = 11,
  parameter  int NM    = 23,
  parameter  int CNT_W = 16,
  localparam int N     = NX + NM + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_abn
);

  fpu #(.NX(NX), .NM(NM)) u_fpu ();

  state_t           state;
  logic             acc_first;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] count;
  logic             p_ready;
  logic             p_valid;
  logic             p_last;
  logic [N-1:0]     p_q;
  logic [N-1:0]     acc_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Products are drained only in ACC; in HOLD the buffered product waits for the next group.
  assign p_ready = (state == ACC);

  fp_mul_stage #(.NX(NX), .NM(NM)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .p_ready  (p_ready),
    .p_valid  (p_valid),
    .p_q      (p_q),
    .p_last   (p_last),
    .fpu_if   (u_fpu.mul_mp)
  );

  assign u_fpu.add_a = acc;
  assign u_fpu.add_b = p_q;

  // The adder assumes normal operands, so zeros on either side are resolved here.
  always_comb begin
    acc_nxt = u_fpu.add_y;
    if (acc_first || acc[N-2:NM] == '0) begin
      acc_nxt = p_q;
    end else if (p_q[N-2:NM] == '0) begin
      acc_nxt = acc;
    end
  end

  assign count_nxt = (&count) ? count : count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc_first <= 1'b1;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_abn   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (p_valid) begin
            acc       <= acc_nxt;
            acc_first <= 1'b0;
            count     <= count_nxt;
            if (p_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_count <= count_nxt;
              out_abn   <= &acc_nxt[N-2:NM];
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            acc_first <= 1'b1;
            count     <= '0;
          end
        end
      endcase
    end
  end

endmodule
